// File: rtl/result_check_monitor.sv
// Snoops the data-memory write bus, arms on a BEGIN symbol written to the test port,
// then checks each result write against an expected-value ROM and reports the outcome.
module result_check_monitor #(
    parameter int                ADDR_W    = 30,
    parameter int                DATA_W    = 32,
    parameter int                IDX_W     = 10,
    parameter int                ERR_W     = 8,
    parameter int                DUR_W     = 16,
    parameter logic [ADDR_W-1:0] TEST_PORT = 30'hFF,
    parameter logic [DATA_W-1:0] BEGIN_SYM = 32'h932,
    parameter logic [IDX_W-1:0]  CHECK_NUM = 10'd149,
    parameter logic [DUR_W-1:0]  TIMEOUT   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    input  logic              wen,
    output logic [IDX_W-1:0]  exp_idx,
    input  logic [DATA_W-1:0] exp_data,
    output logic [ERR_W-1:0]  error_num,
    output logic [DUR_W-1:0]  duration,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [DATA_W-1:0] fail_data,
    output logic              fail_valid,
    output logic              timed_out,
    output logic              finish,
    output logic              pass
);

    // state  | meaning
    // IDLE   | waiting for BEGIN_SYM on the test port
    // CHECK  | comparing result writes, counting cycles
    // REPORT | results frozen until rst or clear
    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    localparam logic [DUR_W-1:0] TO_LAST = TIMEOUT - DUR_W'(1);

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [DUR_W-1:0]    dur_q, dur_d;
    logic [IDX_W-1:0]    fidx_q, fidx_d;
    logic [DATA_W-1:0]   fdata_q, fdata_d;
    logic                fvalid_q, fvalid_d;
    logic                to_q, to_d;
    logic                armed_q;
    logic                hit;

    // A write stalled across several cycles keeps wen high; only its first cycle counts.
    assign hit = wen & armed_q & (addr == TEST_PORT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            err_q    <= '1;
            dur_q    <= '0;
            fidx_q   <= '0;
            fdata_q  <= '0;
            fvalid_q <= 1'b0;
            to_q     <= 1'b0;
            armed_q  <= 1'b1;
        end else if (clear) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            err_q    <= '1;
            dur_q    <= '0;
            fidx_q   <= '0;
            fdata_q  <= '0;
            fvalid_q <= 1'b0;
            to_q     <= 1'b0;
            armed_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            err_q    <= err_d;
            dur_q    <= dur_d;
            fidx_q   <= fidx_d;
            fdata_q  <= fdata_d;
            fvalid_q <= fvalid_d;
            to_q     <= to_d;
            armed_q  <= ~wen;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        dur_d    = dur_q;
        fidx_d   = fidx_q;
        fdata_d  = fdata_q;
        fvalid_d = fvalid_q;
        to_d     = to_q;
        case (state_q)
            IDLE: begin
                idx_d    = '0;
                err_d    = '1;
                dur_d    = '0;
                fidx_d   = '0;
                fdata_d  = '0;
                fvalid_d = 1'b0;
                if (hit && data == BEGIN_SYM) begin
                    err_d   = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (dur_q != '1) dur_d = dur_q + 1'b1;
                if (idx_q == CHECK_NUM) begin
                    state_d = REPORT;
                end else begin
                    if (hit) begin
                        idx_d = idx_q + 1'b1;
                        if (data != exp_data) begin
                            if (err_q != '1) err_d = err_q + 1'b1;
                            if (!fvalid_q) begin
                                fidx_d   = idx_q;
                                fdata_d  = data;
                                fvalid_d = 1'b1;
                            end
                        end
                    end
                    // A hit landing on the timeout cycle is still scored above.
                    if (TIMEOUT != '0 && dur_q == TO_LAST) begin
                        to_d    = 1'b1;
                        state_d = REPORT;
                    end
                end
            end
            REPORT: ;
            default: state_d = IDLE;
        endcase
    end

    assign exp_idx    = idx_q;
    assign error_num  = err_q;
    assign duration   = dur_q;
    assign fail_idx   = fidx_q;
    assign fail_data  = fdata_q;
    assign fail_valid = fvalid_q;
    assign timed_out  = to_q;
    assign finish     = (state_q == REPORT);
    assign pass       = finish & (err_q == '0) & ~to_q;

endmodule

// File: tb/tb_result_check_monitor.sv
// Directed bench for result_check_monitor: a default instance plus a TIMEOUT=100
// instance sharing the snooped bus, each fed by its own model ROM.
module tb_result_check_monitor;

    localparam logic [29:0] TP    = 30'hFF;
    localparam logic [31:0] BEGIN = 32'h932;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] data = '0;
    logic        wen = 1'b0;

    logic [9:0]  exp_idx, exp_idx_to;
    logic [31:0] exp_data, exp_data_to;
    logic [7:0]  error_num, error_num_to;
    logic [15:0] duration, duration_to;
    logic [9:0]  fail_idx, fail_idx_to;
    logic [31:0] fail_data, fail_data_to;
    logic        fail_valid, fail_valid_to, timed_out, timed_out_to;
    logic        finish, finish_to, pass, pass_to;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [9:0] i);
        return {16'hC0DE, 6'h0, i} ^ 32'h0000_5A5A;
    endfunction

    assign exp_data    = rom(exp_idx);
    assign exp_data_to = rom(exp_idx_to);

    result_check_monitor dut (
        .clk(clk), .rst(rst), .clear(clear), .addr(addr), .data(data), .wen(wen),
        .exp_idx(exp_idx), .exp_data(exp_data), .error_num(error_num),
        .duration(duration), .fail_idx(fail_idx), .fail_data(fail_data),
        .fail_valid(fail_valid), .timed_out(timed_out), .finish(finish), .pass(pass)
    );

    result_check_monitor #(.TIMEOUT(16'd100)) dut_to (
        .clk(clk), .rst(rst), .clear(clear), .addr(addr), .data(data), .wen(wen),
        .exp_idx(exp_idx_to), .exp_data(exp_data_to), .error_num(error_num_to),
        .duration(duration_to), .fail_idx(fail_idx_to), .fail_data(fail_data_to),
        .fail_valid(fail_valid_to), .timed_out(timed_out_to), .finish(finish_to),
        .pass(pass_to)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [29:0] a, input logic [31:0] d, input logic w);
        addr = a;
        data = d;
        wen  = w;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic bad);
        step(TP, rom(10'(k)) ^ {31'b0, bad}, 1'b1);
        step('0, '0, 1'b0);
    endtask

    task automatic do_begin();
        step(TP, BEGIN, 1'b1);
        step('0, '0, 1'b0);
    endtask

    task automatic restart();
        clear = 1'b1;
        step('0, '0, 1'b0);
        clear = 1'b0;
    endtask

    // BEGIN, 148 writes, last write checked for the one-cycle finish latency.
    task automatic full_run(input string tag);
        do_begin();
        for (int k = 0; k < 148; k++) wr(k, 1'b0);
        step(TP, rom(10'd148), 1'b1);
        chk({tag, "_idx_last"}, 64'(exp_idx), 64'd149);
        chk({tag, "_finish_early"}, 64'(finish), 64'd0);
        step('0, '0, 1'b0);
        chk({tag, "_finish"}, 64'(finish), 64'd1);
        chk({tag, "_err"}, 64'(error_num), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd1);
    endtask

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
        logic        w;
        logic [7:0]  exp_err;
        logic        exp_fin;
    } vec_t;

    vec_t idle_vec[6];

    initial begin
        idle_vec[0] = '{TP,          32'h931, 1'b1, 8'hFF, 1'b0};
        idle_vec[1] = '{TP + 30'd1,  BEGIN,   1'b1, 8'hFF, 1'b0};
        idle_vec[2] = '{30'h0,       BEGIN,   1'b1, 8'hFF, 1'b0};
        idle_vec[3] = '{TP,          BEGIN,   1'b0, 8'hFF, 1'b0};
        idle_vec[4] = '{TP,          32'h0,   1'b1, 8'hFF, 1'b0};
        idle_vec[5] = '{TP,          BEGIN,   1'b1, 8'h00, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_err", 64'(error_num), 64'hFF);
        chk("rst_idx", 64'(exp_idx), 64'd0);
        chk("rst_dur", 64'(duration), 64'd0);
        chk("rst_fvalid", 64'(fail_valid), 64'd0);
        chk("rst_finish", 64'(finish), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_timed_out", 64'(timed_out), 64'd0);
        rst = 1'b1;
        step('0, '0, 1'b0);

        // T5: only a true BEGIN hit (last vector) leaves IDLE
        for (int i = 0; i < 6; i++) begin
            step(idle_vec[i].a, idle_vec[i].d, idle_vec[i].w);
            chk($sformatf("idle_err[%0d]", i), 64'(error_num), 64'(idle_vec[i].exp_err));
            chk($sformatf("idle_fin[%0d]", i), 64'(finish), 64'(idle_vec[i].exp_fin));
            chk($sformatf("idle_dur[%0d]", i), 64'(duration), 64'd0);
            step('0, '0, 1'b0);
        end
        restart();
        chk("clear_err", 64'(error_num), 64'hFF);
        chk("clear_dur", 64'(duration), 64'd0);

        // T1
        full_run("t1");
        chk("t1_dur", 64'(duration), 64'd299);
        chk("t1_timed_out", 64'(timed_out), 64'd0);
        step(TP, BEGIN, 1'b1);
        step('0, '0, 1'b0);
        chk("t1_frozen_dur", 64'(duration), 64'd299);
        chk("t1_frozen_idx", 64'(exp_idx), 64'd149);

        // T2: write 3 stalled for 5 cycles
        restart();
        do_begin();
        for (int k = 0; k < 3; k++) wr(k, 1'b0);
        repeat (5) step(TP, rom(10'd3), 1'b1);
        step('0, '0, 1'b0);
        chk("t2_stall_idx", 64'(exp_idx), 64'd4);
        for (int k = 4; k < 149; k++) wr(k, 1'b0);
        chk("t2_finish", 64'(finish), 64'd1);
        chk("t2_err", 64'(error_num), 64'd0);
        chk("t2_pass", 64'(pass), 64'd1);

        // T3: writes 7 and 40 corrupted
        restart();
        do_begin();
        for (int k = 0; k < 149; k++) wr(k, (k == 7) || (k == 40));
        chk("t3_finish", 64'(finish), 64'd1);
        chk("t3_err", 64'(error_num), 64'd2);
        chk("t3_fail_idx", 64'(fail_idx), 64'd7);
        chk("t3_fail_data", 64'(fail_data), 64'(rom(10'd7) ^ 32'h1));
        chk("t3_fail_valid", 64'(fail_valid), 64'd1);
        chk("t3_pass", 64'(pass), 64'd0);

        // T4: TIMEOUT=100 instance, only 10 writes
        restart();
        do_begin();
        for (int k = 0; k < 10; k++) wr(k, 1'b0);
        for (int c = 0; c < 200 && !finish_to; c++) step('0, '0, 1'b0);
        chk("t4_finish", 64'(finish_to), 64'd1);
        chk("t4_timed_out", 64'(timed_out_to), 64'd1);
        chk("t4_dur", 64'(duration_to), 64'd100);
        chk("t4_pass", 64'(pass_to), 64'd0);
        chk("t4_idx", 64'(exp_idx_to), 64'd10);
        chk("t4_err", 64'(error_num_to), 64'd0);
        chk("t4_default_busy", 64'(finish), 64'd0);

        // T6: async reset mid-CHECK, then a clean run
        restart();
        do_begin();
        for (int k = 0; k < 5; k++) wr(k, 1'b0);
        rst = 1'b0;
        #1;
        chk("t6_err", 64'(error_num), 64'hFF);
        chk("t6_idx", 64'(exp_idx), 64'd0);
        chk("t6_dur", 64'(duration), 64'd0);
        chk("t6_finish", 64'(finish), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        step('0, '0, 1'b0);
        full_run("t6");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
